// File: rtl/sseg_bcd_timer.sv
// BCD up/down timer with a multiplexed, active-low seven-segment display.
// Define SSEG_TIMER_BLANK_LZ_EN to blank leading-zero digits (digit 0 always shown).
module sseg_bcd_timer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 10,
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  SW,
    input  logic                  dir,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    output logic [4*N_DIGITS-1:0] count,
    output logic                  wrap,
    output logic [7:0]            sseg,
    output logic [7:0]            AN
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int W        = 4 * N_DIGITS;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int RW       = $clog2(REFRESH_DIV);
    localparam int IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [W:0]    stepped;
    logic [RW-1:0] ref_cnt;
    logic [IW-1:0] idx;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < N_DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
        return r;
    endfunction

    // Returns {ripple_out, next}; ripple_out set means every digit rolled over.
    function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic down);
        logic [W-1:0] r;
        logic         ripple;
        r      = v;
        ripple = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (ripple) begin
                if (!down) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        ripple      = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        ripple      = 1'b0;
                    end
                end
            end
        end
        return {ripple, r};
    endfunction

    function automatic logic [7:0] decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign tick = SW && (presc == PRESC_MAX);

    always_comb stepped = bcd_step(count, dir);
    always_comb digit   = count[4*idx +: 4];

`ifdef SSEG_TIMER_BLANK_LZ_EN
    // NOTE: blank gets its default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        blank = (idx != '0);
        for (int i = 0; i < N_DIGITS; i++)
            if (i >= int'(idx) && count[4*i +: 4] != 4'd0) blank = 1'b0;
    end
`else
    assign blank = 1'b0;
`endif

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (SW) begin
            presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
        end
    end

    // clr beats load beats tick; a tick coinciding with load is dropped.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (load) begin
                count <= sanitize(load_val);
            end else if (tick) begin
                count <= stepped[W-1:0];
                wrap  <= stepped[W];
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REF_MAX) begin
            ref_cnt <= '0;
            idx     <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            sseg <= 8'hFF;
            AN   <= 8'hFF;
        end else begin
            sseg <= blank ? 8'hFF : decode(digit);
            AN   <= ~(8'd1 << idx);
        end
    end

endmodule

// File: tb/tb_sseg_bcd_timer.sv
// Self-checking bench for sseg_bcd_timer: directed steps plus randomized traffic
// against a decimal-arithmetic reference model.
module tb_sseg_bcd_timer;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MAXV = 9999;
    localparam int TDIV = 10;
    localparam int RDIV = 4;

    localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic         sysclk   = 1'b0;
    logic         rst      = 1'b0;
    logic         SW       = 1'b0;
    logic         dir      = 1'b0;
    logic         clr      = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         wrap;
    logic [7:0]   sseg;
    logic [7:0]   AN;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: count as a plain decimal integer.
    int         m_val;
    int         m_pre;
    int         m_t;
    logic       m_wrap;
    logic [7:0] m_sseg;
    logic [7:0] m_an;

    int nw;
    int guard;

    sseg_bcd_timer #(
        .CLK_HZ     (100),
        .TICK_HZ    (10),
        .N_DIGITS   (N),
        .REFRESH_DIV(RDIV)
    ) dut (
        .sysclk  (sysclk),
        .rst     (rst),
        .SW      (SW),
        .dir     (dir),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .wrap    (wrap),
        .sseg    (sseg),
        .AN      (AN)
    );

    always #5 sysclk = ~sysclk;

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [W-1:0] lv);
        int r;
        int nib;
        r = 0;
        for (int i = 0; i < N; i++) begin
            nib = int'(lv[4*i +: 4]);
            if (nib <= 9) r = r + nib * pow10(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val  = 0;
        m_pre  = 0;
        m_t    = 0;
        m_wrap = 1'b0;
        m_sseg = 8'hFF;
        m_an   = 8'hFF;
    endtask

    task automatic model_step();
        int idx;
        int dg;
        bit tk;
        idx    = (m_t / RDIV) % N;
        dg     = (m_val / pow10(idx)) % 10;
        m_an   = 8'hFF ^ (8'd1 << idx);
        m_sseg = SEG[dg];
`ifdef SSEG_TIMER_BLANK_LZ_EN
        if (idx > 0 && m_val < pow10(idx)) m_sseg = 8'hFF;
`endif
        tk     = SW && (m_pre == TDIV - 1);
        m_wrap = 1'b0;
        if (clr) begin
            m_val = 0;
            m_pre = 0;
        end else begin
            if (SW) m_pre = (m_pre + 1) % TDIV;
            if (load) begin
                m_val = from_load(load_val);
            end else if (tk) begin
                if (!dir) begin
                    m_wrap = (m_val == MAXV);
                    m_val  = (m_val + 1) % (MAXV + 1);
                end else begin
                    m_wrap = (m_val == 0);
                    m_val  = (m_val + MAXV) % (MAXV + 1);
                end
            end
        end
        m_t++;
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge sysclk);
        model_step();
        @(negedge sysclk);
        check("count", 32'(count), 32'(to_bcd(m_val)));
        check("wrap",  32'(wrap),  32'(m_wrap));
        check("sseg",  32'(sseg),  32'(m_sseg));
        check("an",    32'(AN),    32'(m_an));
    endtask

    // Align to the start of a digit-0 slot, then check 16 cycles of scanning.
    task automatic scan16(input string tag, input logic [31:0] segs);
        logic [31:0] an_seq;
        an_seq = 32'hF7FB_FDFE;
        guard  = 0;
        while ((m_t % (RDIV * N)) != 0 && guard < 20) begin
            cyc();
            guard++;
        end
        for (int k = 0; k < 16; k++) begin
            cyc();
            check({tag, "_an"},   32'(AN),      32'(an_seq[8*(k/4) +: 8]));
            check({tag, "_sseg"}, 32'(sseg),    32'(segs[8*(k/4) +: 8]));
            check({tag, "_anhi"}, 32'(AN[7:4]), 32'hF);
        end
    endtask

    initial begin
        // Reset held for three cycles
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            check("rst_sseg", 32'(sseg), 32'hFF);
            check("rst_an",   32'(AN),   32'hFF);
        end
        rst = 1'b1;
        check("rst_count", 32'(count), 32'h0);
        cyc();
        check("first_an",   32'(AN),   32'hFE);
        check("first_sseg", 32'(sseg), 32'hC0);

        // Count up 100 cycles from zero
        SW  = 1'b1;
        dir = 1'b0;
        for (int i = 0; i < 100; i++) cyc();
        check("up100", 32'(count), 32'h0010);

        // Wrap up
        load = 1'b1; load_val = 16'h9999;
        cyc();
        load = 1'b0;
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (wrap === 1'b1) nw++;
        end
        check("wrap_up_count", 32'(count), 32'h0000);
        check("wrap_up_once",  32'(nw),    32'd1);

        // Wrap down
        load = 1'b1; load_val = 16'h0000; dir = 1'b1;
        cyc();
        load = 1'b0;
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (wrap === 1'b1) nw++;
        end
        check("wrap_dn_count", 32'(count), 32'h9999);
        check("wrap_dn_once",  32'(nw),    32'd1);

        // clr beats load
        dir = 1'b0;
        clr = 1'b1; load = 1'b1; load_val = 16'h1234;
        cyc();
        clr = 1'b0; load = 1'b0;
        check("clr_wins", 32'(count), 32'h0000);

        // Prescaler to 5, then load non-BCD and freeze
        for (int i = 0; i < 5; i++) cyc();
        SW = 1'b0; load = 1'b1; load_val = 16'h12A4;
        cyc();
        load = 1'b0;
        check("load_nonbcd", 32'(count), 32'h1204);
        for (int i = 0; i < 50; i++) cyc();
        check("hold", 32'(count), 32'h1204);
        SW = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("resume_pre", 32'(count), 32'h1204);
        cyc();
        check("resume_tick", 32'(count), 32'h1205);

        // Load on a tick cycle loses the tick
        guard = 0;
        while (m_pre != TDIV - 1 && guard < 12) begin
            cyc();
            guard++;
        end
        load = 1'b1; load_val = 16'h0042;
        cyc();
        load = 1'b0;
        check("load_on_tick", 32'(count), 32'h0042);
        for (int i = 0; i < 9; i++) cyc();
        check("after_lost_tick", 32'(count), 32'h0042);
        cyc();
        check("next_tick", 32'(count), 32'h0043);

        // Scan of 1234
        SW = 1'b0; load = 1'b1; load_val = 16'h1234;
        cyc();
        load = 1'b0;
        scan16("scan1234", 32'hF9A4_B099);

        // Leading zeros: 0007
        load = 1'b1; load_val = 16'h0007;
        cyc();
        load = 1'b0;
`ifdef SSEG_TIMER_BLANK_LZ_EN
        scan16("scan0007", 32'hFFFF_FFF8);
`else
        scan16("scan0007", 32'hC0C0_C0F8);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            SW   = ($urandom_range(0, 3) != 0);
            dir  = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 39) == 0);
            load = ($urandom_range(0, 19) == 0);
            for (int d = 0; d < N; d++) load_val[4*d +: 4] = 4'($urandom_range(0, 11));
            cyc();
        end

        // Reset mid-scan
        SW = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_sseg",  32'(sseg),  32'hFF);
        check("mid_rst_an",    32'(AN),    32'hFF);
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_wrap",  32'(wrap),  32'h0);
        model_reset();
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        check("hold_rst_an", 32'(AN), 32'hFF);
        rst = 1'b1;
        cyc();
        check("restart_an",   32'(AN),   32'hFE);
        check("restart_sseg", 32'(sseg), 32'hC0);
        SW = 1'b1;
        for (int i = 0; i < 20; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
